// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory, one transaction in flight.
// Data port has priority; a starvation counter guarantees fetch a slot after STARVE_MAX data wins.
module mem_bus_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   // fetch port (read-only)
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvld,
   output logic [31:0] if_rdata,
   // data port
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_wren,
   input  logic [31:0] d_wrdata,
   output logic        d_gnt,
   output logic        d_rvld,
   output logic [31:0] d_rdata,
   // memory side
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wren,
   output logic [31:0] mem_wrdata,
   input  logic        mem_ready,
   input  logic        mem_rvld,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   // debug visibility
   output logic [1:0]  state_dbg,
   output logic [3:0]  starve_cnt_dbg
);

   // Handshakes: a grant is a one-cycle combinational pulse in IDLE and the payload is
   // captured on that edge; mem_req holds until mem_ready; rvld is a one-cycle pulse.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state_q, state_d;
   logic [3:0]  starve_q;
   logic        owner_q;      // 1: data port, 0: fetch port
   logic [31:0] addr_q;
   logic [3:0]  wren_q;
   logic [31:0] wrdata_q;
   logic        rst_q;        // blocks grants in the first cycle after reset

   always_comb begin
      state_d = state_q;
      if_gnt  = 1'b0;
      d_gnt   = 1'b0;
      if_rvld = 1'b0;
      d_rvld  = 1'b0;
      mem_req = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (!rst_q) begin
                  if (d_req && !(if_req && (starve_q == STARVE_LIM))) begin
                     d_gnt = 1'b1;
                  end else if (if_req) begin
                     if_gnt = 1'b1;
                  end
                  if (d_req || if_req) begin
                     state_d = REQ;
                  end
               end
            end
            REQ: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  state_d = (wren_q != 4'd0) ? IDLE : RESP;
               end
            end
            RESP: begin
               if (mem_rvld) begin
                  if (owner_q) begin
                     d_rvld = 1'b1;
                  end else begin
                     if_rvld = 1'b1;
                  end
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         starve_q <= 4'd0;
         owner_q  <= 1'b0;
         addr_q   <= 32'd0;
         wren_q   <= 4'd0;
         wrdata_q <= 32'd0;
         rst_q    <= 1'b1;
      end else begin
         rst_q   <= 1'b0;
         state_q <= state_d;
         if (d_gnt) begin
            owner_q  <= 1'b1;
            addr_q   <= d_addr;
            wren_q   <= d_wren;
            wrdata_q <= d_wrdata;
            if (if_req) begin
               starve_q <= (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
            end
         end else if (if_gnt) begin
            owner_q  <= 1'b0;
            addr_q   <= if_addr;
            wren_q   <= 4'd0;
            wrdata_q <= 32'd0;
            starve_q <= 4'd0;
         end
      end
   end

   assign mem_addr       = addr_q;
   assign mem_wren       = wren_q;
   assign mem_wrdata     = wrdata_q;
   assign if_rdata       = mem_rdata;
   assign d_rdata        = mem_rdata;
   assign busy           = !rst && (state_q != IDLE);
   assign state_dbg      = state_q;
   assign starve_cnt_dbg = starve_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_gnt, if_rvld;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = 32'd0;
   logic [3:0]  d_wren = 4'd0;
   logic [31:0] d_wrdata = 32'd0;
   logic        d_gnt, d_rvld;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wren;
   logic [31:0] mem_wrdata;
   logic        mem_ready = 1'b0;
   logic        mem_rvld = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        busy;
   logic [1:0]  state_dbg;
   logic [3:0]  starve_cnt_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvld(if_rvld), .if_rdata(if_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wren(d_wren), .d_wrdata(d_wrdata),
      .d_gnt(d_gnt), .d_rvld(d_rvld), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wrdata(mem_wrdata),
      .mem_ready(mem_ready), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
      .busy(busy), .state_dbg(state_dbg), .starve_cnt_dbg(starve_cnt_dbg)
   );

   // driver helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; d_req = 1'b0; d_wren = 4'd0;
      mem_ready = 1'b0; mem_rvld = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      if_req = 1'b1; d_req = 1'b1; mem_rvld = 1'b1; mem_ready = 1'b1;
      sample();
      checks++;
      if ({if_gnt, d_gnt, mem_req, if_rvld, d_rvld, busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 000000", {if_gnt, d_gnt, mem_req, if_rvld, d_rvld, busy});
      end
      checks++;
      if (state_dbg !== 2'd0 || starve_cnt_dbg !== 4'd0 || mem_addr !== 32'd0 || mem_wren !== 4'd0) begin
         errors++;
         $display("FAIL reset_state got st=%0d cnt=%0d addr=%h wren=%h exp 0", state_dbg, starve_cnt_dbg, mem_addr, mem_wren);
      end
      tick();
      rst = 1'b0;
      sample();
      checks++;
      if ({if_gnt, d_gnt, mem_req, if_rvld, d_rvld, busy} !== 6'b0) begin
         errors++;
         $display("FAIL post_reset_cycle got %b exp 000000", {if_gnt, d_gnt, mem_req, if_rvld, d_rvld, busy});
      end
      tick();
      idle_inputs();
      sample();
   endtask

   task automatic test_fetch_read();
      tick();
      if_req = 1'b1; if_addr = 32'h100;
      sample();
      checks++;
      if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fetch_grant got gnt=%b dgnt=%b mreq=%b busy=%b exp 1 0 0 0", if_gnt, d_gnt, mem_req, busy);
      end
      tick();
      if_req = 1'b0; if_addr = 32'hBAD0_0000; mem_ready = 1'b1;
      sample();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wren !== 4'd0 || busy !== 1'b1 || if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL fetch_memreq got req=%b addr=%h wren=%h busy=%b exp 1 00000100 0 1", mem_req, mem_addr, mem_wren, busy);
      end
      tick();
      mem_ready = 1'b0; mem_rvld = 1'b1; mem_rdata = 32'hDEADBEEF;
      sample();
      checks++;
      if (if_rvld !== 1'b1 || if_rdata !== 32'hDEADBEEF || d_rvld !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL fetch_rvld got rvld=%b data=%h drvld=%b mreq=%b exp 1 deadbeef 0 0", if_rvld, if_rdata, d_rvld, mem_req);
      end
      tick();
      mem_rvld = 1'b0;
      sample();
      checks++;
      if (busy !== 1'b0 || if_rvld !== 1'b0) begin
         errors++;
         $display("FAIL fetch_done got busy=%b rvld=%b exp 0 0", busy, if_rvld);
      end
   endtask

   task automatic test_data_write();
      tick();
      d_req = 1'b1; d_addr = 32'h2000; d_wren = 4'b0011; d_wrdata = 32'h1234;
      sample();
      checks++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL write_grant got dgnt=%b ifgnt=%b exp 1 0", d_gnt, if_gnt);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         d_req = 1'b0; d_addr = 32'hFFFF; d_wren = 4'hF; d_wrdata = 32'h0;
         mem_ready = (i == 3);
         sample();
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_wren !== 4'b0011 || mem_wrdata !== 32'h1234
             || if_rvld !== 1'b0 || d_rvld !== 1'b0) begin
            errors++;
            $display("FAIL write_hold[%0d] got req=%b addr=%h wren=%h wd=%h exp 1 00002000 3 00001234", i, mem_req, mem_addr, mem_wren, mem_wrdata);
         end
      end
      tick();
      idle_inputs();
      sample();
      checks++;
      if (busy !== 1'b0 || state_dbg !== 2'd0 || mem_req !== 1'b0 || d_rvld !== 1'b0) begin
         errors++;
         $display("FAIL write_done got busy=%b st=%0d mreq=%b exp 0 0 0", busy, state_dbg, mem_req);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_gnt;
      logic [4:0] exp_mreq;
      exp_gnt  = 5'b10101;
      exp_mreq = 5'b01010;
      tick();
      d_req = 1'b1; d_addr = 32'h700; d_wren = 4'hF; d_wrdata = 32'hA5; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample();
         checks++;
         if (d_gnt !== exp_gnt[i] || mem_req !== exp_mreq[i]) begin
            errors++;
            $display("FAIL b2b_write[%0d] got gnt=%b mreq=%b exp %b %b", i, d_gnt, mem_req, exp_gnt[i], exp_mreq[i]);
         end
         tick();
      end
      d_req = 1'b0;
      sample();
      tick();
      idle_inputs();
      sample();
   endtask

   task automatic test_starvation();
      logic [9:0] exp_is_data;
      int         exp_cnt [10];
      int         n;
      int         cyc;
      exp_is_data = 10'b0111101111;
      exp_cnt = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
      n = 0;
      cyc = 0;
      tick();
      if_req = 1'b1; if_addr = 32'h500; d_req = 1'b1; d_addr = 32'h600; d_wren = 4'd0;
      mem_ready = 1'b1; mem_rvld = 1'b1; mem_rdata = 32'h55;
      while (n < 10 && cyc < 80) begin
         sample();
         if (if_gnt || d_gnt) begin
            checks++;
            if (d_gnt !== exp_is_data[n] || if_gnt !== !exp_is_data[n]) begin
               errors++;
               $display("FAIL starve_order[%0d] got dgnt=%b ifgnt=%b exp data=%b", n, d_gnt, if_gnt, exp_is_data[n]);
            end
            checks++;
            if (starve_cnt_dbg !== 4'(exp_cnt[n])) begin
               errors++;
               $display("FAIL starve_cnt[%0d] got %0d exp %0d", n, starve_cnt_dbg, exp_cnt[n]);
            end
            n++;
         end
         cyc++;
         tick();
      end
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL starve_timeout got %0d grants exp 10", n);
      end
      if_req = 1'b0; d_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample();
         if (!busy) break;
         tick();
      end
      checks++;
      if (busy !== 1'b0 || starve_cnt_dbg !== 4'd0) begin
         errors++;
         $display("FAIL starve_drain got busy=%b cnt=%0d exp 0 0", busy, starve_cnt_dbg);
      end
      tick();
      idle_inputs();
      sample();
   endtask

   task automatic test_stray_rvld();
      tick();
      mem_rvld = 1'b1;
      sample();
      checks++;
      if (if_rvld !== 1'b0 || d_rvld !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL stray_idle got rvld=%b%b st=%0d exp 00 0", if_rvld, d_rvld, state_dbg);
      end
      tick();
      if_req = 1'b1; if_addr = 32'h80; mem_rvld = 1'b0;
      sample();
      checks++;
      if (state_dbg !== 2'd0 || if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL stray_idle_after got st=%0d gnt=%b exp 0 1", state_dbg, if_gnt);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         if_req = 1'b0; mem_ready = 1'b0; mem_rvld = 1'b1;
         sample();
         checks++;
         if (if_rvld !== 1'b0 || d_rvld !== 1'b0 || state_dbg !== 2'd1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL stray_req[%0d] got rvld=%b%b st=%0d mreq=%b exp 00 1 1", i, if_rvld, d_rvld, state_dbg, mem_req);
         end
      end
      tick();
      mem_ready = 1'b1; mem_rvld = 1'b0;
      sample();
      tick();
      mem_ready = 1'b0; mem_rvld = 1'b1; mem_rdata = 32'h0BAD_F00D;
      sample();
      checks++;
      if (if_rvld !== 1'b1 || if_rdata !== 32'h0BAD_F00D || d_rvld !== 1'b0) begin
         errors++;
         $display("FAIL stray_resp got rvld=%b data=%h exp 1 0badf00d", if_rvld, if_rdata);
      end
      tick();
      idle_inputs();
      sample();
   endtask

   task automatic test_reset_in_resp();
      tick();
      if_req = 1'b1; if_addr = 32'h300;
      sample();
      tick();
      if_req = 1'b0; mem_ready = 1'b1;
      sample();
      tick();
      mem_ready = 1'b0;
      sample();
      checks++;
      if (state_dbg !== 2'd2) begin
         errors++;
         $display("FAIL rst_resp_setup got st=%0d exp 2", state_dbg);
      end
      tick();
      rst = 1'b1;
      sample();
      checks++;
      if (if_rvld !== 1'b0 || d_rvld !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_resp_during got rvld=%b%b busy=%b mreq=%b exp 00 0 0", if_rvld, d_rvld, busy, mem_req);
      end
      tick();
      rst = 1'b0; mem_rvld = 1'b1; mem_rdata = 32'h1111_2222;
      sample();
      checks++;
      if (if_rvld !== 1'b0 || d_rvld !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL rst_late_rvld got rvld=%b%b busy=%b st=%0d exp 00 0 0", if_rvld, d_rvld, busy, state_dbg);
      end
      tick();
      mem_rvld = 1'b0; d_req = 1'b1; d_addr = 32'h40; d_wren = 4'd0;
      sample();
      checks++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL rst_next_grant got dgnt=%b ifgnt=%b exp 1 0", d_gnt, if_gnt);
      end
      tick();
      d_req = 1'b0; mem_ready = 1'b1;
      sample();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_wren !== 4'd0) begin
         errors++;
         $display("FAIL rst_next_req got req=%b addr=%h wren=%h exp 1 00000040 0", mem_req, mem_addr, mem_wren);
      end
      tick();
      mem_ready = 1'b0; mem_rvld = 1'b1; mem_rdata = 32'hCAFE_0001;
      sample();
      checks++;
      if (d_rvld !== 1'b1 || d_rdata !== 32'hCAFE_0001 || if_rvld !== 1'b0) begin
         errors++;
         $display("FAIL rst_next_resp got drvld=%b data=%h ifrvld=%b exp 1 cafe0001 0", d_rvld, d_rdata, if_rvld);
      end
      tick();
      idle_inputs();
      sample();
   endtask

   task automatic test_withdrawn();
      tick();
      if_req = 1'b1; if_addr = 32'h900;
      sample();
      tick();
      if_req = 1'b0; d_req = 1'b1; d_addr = 32'h3000; d_wren = 4'hF; d_wrdata = 32'h77;
      sample();
      tick();
      mem_ready = 1'b1;
      sample();
      checks++;
      if (d_gnt !== 1'b0 || mem_addr !== 32'h900 || mem_wren !== 4'd0) begin
         errors++;
         $display("FAIL withdraw_req got dgnt=%b addr=%h wren=%h exp 0 00000900 0", d_gnt, mem_addr, mem_wren);
      end
      tick();
      d_req = 1'b0; mem_ready = 1'b0; mem_rvld = 1'b1; mem_rdata = 32'h99;
      sample();
      checks++;
      if (if_rvld !== 1'b1 || d_rvld !== 1'b0 || d_gnt !== 1'b0) begin
         errors++;
         $display("FAIL withdraw_resp got ifrvld=%b drvld=%b dgnt=%b exp 1 0 0", if_rvld, d_rvld, d_gnt);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         mem_rvld = 1'b0;
         sample();
         checks++;
         if (d_gnt !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_idle[%0d] got dgnt=%b mreq=%b busy=%b exp 0 0 0", i, d_gnt, mem_req, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_read();
      test_data_write();
      test_back_to_back();
      test_starvation();
      test_stray_rvld();
      test_reset_in_resp();
      test_withdrawn();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive data-port wins allowed while fetch is pending; legal range 1..15.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have if_req input 1, if_addr input 32, if_gnt output 1, if_rvld output 1, if_rdata output 32 for the fetch port (read-only).
REQ-005 SHALL have d_req input 1, d_addr input 32, d_wren input 4 (byte enables; 0 means read), d_wrdata input 32, d_gnt output 1, d_rvld output 1, d_rdata output 32 for the data port.
REQ-006 SHALL have mem_req output 1, mem_addr output 32, mem_wren output 4, mem_wrdata output 32, mem_ready input 1, mem_rvld input 1, mem_rdata input 32 toward the single-port memory.
REQ-007 SHALL have busy output 1, high in any state other than IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, REQ and RESP, with one transaction outstanding at most.
REQ-009 SHALL, in IDLE, assert exactly one grant combinationally when at least one req is high; otherwise no grant.
REQ-010 SHALL select data over fetch when both request, except fetch wins when starve_cnt == STARVE_MAX.
REQ-011 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, when data is granted while if_req is high.
REQ-012 starve_cnt SHALL clear when fetch is granted, and SHALL otherwise hold.
REQ-013 SHALL, on the grant edge, capture addr, wren (fetch: 0), wrdata (fetch: 0) and owner, then move IDLE->REQ.
REQ-014 Requester SHALL hold req and payload stable until its gnt; the arbiter SHALL ignore payload changes after capture.
REQ-015 SHALL drive mem_req=1 only in REQ, with mem_addr/mem_wren/mem_wrdata taken from the captured registers.
REQ-016 SHALL, in REQ with mem_ready=1: go REQ->IDLE for writes (wren!=0) and REQ->RESP for reads; with mem_ready=0, hold REQ with outputs stable.
REQ-017 SHALL, in RESP with mem_rvld=1, pulse the owner's rvld in the same cycle, pass mem_rdata to the owner's rdata, and go RESP->IDLE.
REQ-018 SHALL hold the non-owner rvld at 0, and SHALL ignore mem_rvld in IDLE and REQ.
REQ-019 if_rdata and d_rdata SHALL equal mem_rdata at all times; they are qualified only by rvld.
REQ-020 SHALL insert no grant in the RESP->IDLE cycle; next grant is earliest in the following IDLE cycle.
REQ-021 Minimum spacing SHALL be 3 cycles per read and 2 cycles per write, with mem_ready/mem_rvld immediate.
REQ-022 A req dropped before its grant SHALL be treated as withdrawn, with no side effects.

Reset
REQ-023 rst SHALL force state=IDLE, starve_cnt=0, owner=0 and captured addr/wren/wrdata=0.
REQ-024 During reset, and in the cycle after rst deasserts, SHALL drive mem_req, if_gnt, d_gnt, if_rvld, d_rvld and busy to 0.
REQ-025 rst asserted in REQ or RESP SHALL abandon the transaction; a late mem_rvld after reset SHALL be discarded.

Verification
REQ-026 Fetch read at 0x100, mem_ready=1 at T+1, mem_rvld=1 at T+2 with data 0xDEADBEEF -> if_gnt at T, mem_req at T+1, if_rvld=1 and if_rdata=0xDEADBEEF at T+2, busy low at T+3.
REQ-027 Data write addr 0x2000, wren=4'b0011, data 0x1234, mem_ready low for 3 cycles -> mem_req/mem_addr/mem_wren held 4 cycles, no rvld, IDLE after acceptance.
REQ-028 Both req high continuously, STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt reaches 4 and then clears.
REQ-029 rst pulse while in RESP, then mem_rvld=1 -> no rvld on either port; next grant proceeds normally.
REQ-030 mem_rvld=1 injected in IDLE and in REQ -> if_rvld=d_rvld=0 and no state change.
REQ-031 d_req raised then dropped during another port's transaction -> no d_gnt and no memory access issued for it.
